spi_xfer_ctrl: RTL and testbench
================================

Name: spi_xfer_ctrl

Overview:
Transfer sequencer for the SPI master datapath. It accepts a word from the register/APB side and programs the baud clock generator through its clock-enable, divider and divider-valid inputs. It shifts the word out on MOSI and captures MISO using the generator's rise/fall edge strobes. It also frames the transfer with CS setup/hold and reports completion. SPI mode 0 only: CPOL=0, MOSI launched on SCLK fall, MISO sampled on SCLK rise.

Parameters:
DATA_W, 8, bits per transfer (2..32)
CS_CNT_W, 8, width of CS setup/hold counter

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset; synchronous, active-high
start_i  input  1  transfer request; accepted only when busy_o=0
tx_data_i  input  DATA_W  word to send, MSB first
clk_div_i  input  8  SCLK divider; even, >=2
busy_o  output  1  high from the accepted start until done_o
done_o  output  1  one-cycle completion pulse
err_o  output  1  one-cycle pulse when start is rejected
rx_data_o  output  DATA_W  captured word; valid from done_o until the next done_o
cs_n_o  output  1  slave select, active low
mosi_o  output  1  serial data out
miso_i  input  1  serial data in
gen_clock_en_o  output  1  to generator clock_en
gen_clk_div_o  output  8  to generator clk_div
gen_clk_div_vld_o  output  1  to generator clk_div_vld
gen_rise_edge_i  input  1  from generator: SCLK about to rise
gen_fall_edge_i  input  1  from generator: SCLK about to fall

Behaviour:
- Reset values (sync, rst_i=1 at posedge):
  - state=IDLE, busy_o=0, done_o=0, err_o=0, rx_data_o=0, cs_n_o=1, mosi_o=0.
  - gen_clock_en_o=0, gen_clk_div_o=0, gen_clk_div_vld_o=0.
  - All counters cleared.
- rst_i mid-transfer aborts immediately to the reset values. rx_data_o is cleared. No done_o.
- IDLE + start_i:
  - If clk_div_i<2: err_o=1 for one cycle, stay IDLE, nothing latched.
  - Else: latch tx_data_i into the shift register. Latch div = {clk_div_i[7:1],1'b0} (odd LSB dropped). Set busy_o=1 and go to SETUP.
- start_i while busy_o=1 is ignored; no err_o.
- gen_clk_div_o holds the latched div. gen_clk_div_vld_o=1 whenever busy_o=1.
- SETUP:
  - cs_n_o=0. mosi_o=shift MSB.
  - Wait div/2 system cycles, counted from the cycle cs_n_o goes low, then go to XFER.
- XFER:
  - gen_clock_en_o=1.
  - On gen_rise_edge_i: rx_shift <= {rx_shift[DATA_W-2:0], miso_i}; bit_cnt++.
  - On gen_fall_edge_i with bit_cnt<DATA_W: shift tx left and drive the next MSB on mosi_o.
  - On gen_fall_edge_i with bit_cnt==DATA_W: clear gen_clock_en_o next cycle, go to HOLD. SCLK is left low.
- HOLD:
  - cs_n_o stays 0 for div/2 cycles, then go to DONE.
- DONE (single cycle):
  - cs_n_o=1. rx_data_o<=rx_shift. done_o=1. busy_o=0 next cycle. Return to IDLE.
- start_i high in the DONE cycle is not accepted. It is accepted the following cycle.
- SCLK edge count per transfer: exactly DATA_W rising and DATA_W falling.
- Transfer length in system cycles, from start accept to done_o: 1 + div/2 + DATA_W*div + div/2 + ~2. The bench checks this ±2.
- Simultaneous rise and fall strobes cannot occur. If both are seen, rise takes priority.

Optional Feature:
SPI_XFER_LSB_FIRST_EN
- Defined: adds input lsb_first_i, latched at start accept. When set, tx shifts right and sends the LSB first; rx fills from the MSB side, so rx_data_o is bit-order consistent.
- Undefined: no such port; MSB first always.

Test Plan:
- Loopback (miso_i=mosi_o), DATA_W=8, clk_div_i=4, tx=0xA5 -> exactly 8 SCLK rises; rx_data_o=0xA5; done_o one pulse; cs_n_o low for ≈2+32+2 cycles.
- clk_div_i=1 and clk_div_i=0 with start_i -> err_o one-cycle pulse each; busy_o stays 0; cs_n_o stays 1.
- clk_div_i=7, tx=0x3C, loopback -> divider used as 6 (gen_clk_div_o=6); rx_data_o=0x3C.
- start_i pulsed again mid-XFER with tx=0xFF -> ignored; only the first word is shifted; a single done_o.
- rst_i asserted at bit 4 of a transfer -> next cycle cs_n_o=1, gen_clock_en_o=0, busy_o=0, rx_data_o=0, no done_o. A subsequent start with 0x5A completes normally.
- SPI_XFER_LSB_FIRST_EN defined, lsb_first_i=1, tx=0x01, miso tied to mosi -> first MOSI bit=1, rx_data_o=0x01.

Source files
------------

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: SPI mode-0 transfer sequencer driving a baud generator, with CS setup/hold framing.
// Optional SPI_XFER_LSB_FIRST_EN adds lsb_first_i for LSB-first shifting.
module spi_xfer_ctrl #(
    parameter int DATA_W   = 8,
    parameter int CS_CNT_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic [7:0]        clk_div_i,
`ifdef SPI_XFER_LSB_FIRST_EN
    input  logic              lsb_first_i,
`endif
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              cs_n_o,
    output logic              mosi_o,
    input  logic              miso_i,
    output logic              gen_clock_en_o,
    output logic [7:0]        gen_clk_div_o,
    output logic              gen_clk_div_vld_o,
    input  logic              gen_rise_edge_i,
    input  logic              gen_fall_edge_i
);
    localparam int BW = $clog2(DATA_W + 1);
    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_e;
    state_e state_q, state_d;
    logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rxo_q, rxo_d;
    logic [7:0] div_q, div_d;
    logic [CS_CNT_W-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bit_q, bit_d;
    logic err_q, err_d, lsb_q, accept, half_done, last_fall, active;
    assign accept    = state_q == IDLE && start_i && clk_div_i >= 8'd2;
    assign half_done = cnt_q == CS_CNT_W'(div_q[7:1] - 7'd1);
    assign last_fall = gen_fall_edge_i && !gen_rise_edge_i && bit_q == BW'(DATA_W);
    assign active    = state_q == SETUP || state_q == XFER || state_q == HOLD;
`ifdef SPI_XFER_LSB_FIRST_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) lsb_q <= 1'b0;
        else if (accept) lsb_q <= lsb_first_i;
    end
`else
    assign lsb_q = 1'b0;
`endif
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            rxo_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rxo_q   <= rxo_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            err_q   <= err_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? SETUP : IDLE;
            SETUP:   state_d = half_done ? XFER : SETUP;
            XFER:    state_d = last_fall ? HOLD : XFER;
            HOLD:    state_d = half_done ? DONE : HOLD;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        tx_d  = tx_q;
        rx_d  = rx_q;
        rxo_d = rxo_q;
        div_d = div_q;
        cnt_d = cnt_q;
        bit_d = bit_q;
        err_d = state_q == IDLE && start_i && clk_div_i < 8'd2;
        if (accept) begin
            tx_d  = tx_data_i;
            rx_d  = '0;
            div_d = {clk_div_i[7:1], 1'b0};
            cnt_d = '0;
            bit_d = '0;
        end
        if (state_q == SETUP || state_q == HOLD) cnt_d = half_done ? '0 : cnt_q + CS_CNT_W'(1);
        // rise wins if the generator ever asserts both strobes
        if (state_q == XFER && gen_rise_edge_i) begin
            rx_d  = lsb_q ? {miso_i, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso_i};
            bit_d = bit_q + BW'(1);
        end else if (state_q == XFER && gen_fall_edge_i && bit_q != BW'(DATA_W))
            tx_d = lsb_q ? {1'b0, tx_q[DATA_W-1:1]} : {tx_q[DATA_W-2:0], 1'b0};
        if (state_q == HOLD && half_done) rxo_d = rx_q;
    end
    always_comb begin
        busy_o            = state_q != IDLE;
        done_o            = state_q == DONE;
        err_o             = err_q;
        rx_data_o         = rxo_q;
        cs_n_o            = !active;
        mosi_o            = active && (lsb_q ? tx_q[0] : tx_q[DATA_W-1]);
        gen_clock_en_o    = state_q == XFER;
        gen_clk_div_o     = div_q;
        gen_clk_div_vld_o = state_q != IDLE;
    end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: randomized self-checking bench with a baud generator and SPI slave model.
module tb_spi_xfer_ctrl;
    localparam int W = 8;
    logic clk = 0, rst = 1, start = 0, loop = 1, lsb = 0, miso;
    logic [W-1:0] tx = '0, slave = '0;
    logic [7:0] cdiv = '0;
    logic busy, done_o, err, cs_n, mosi, gen_en, gen_vld, g_rise, g_fall, sclk = 0;
    logic [W-1:0] rx;
    logic [7:0] gen_div;
    int pass_n = 0, total_n = 0;
    int rise_tot = 0, fall_tot = 0, cs_tot = 0, done_tot = 0, err_tot = 0, rise_base = 0, gcnt = 0, idx;
    logic [31:0] mosi_sh = '0;

    spi_xfer_ctrl #(.DATA_W(W), .CS_CNT_W(8)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .tx_data_i(tx), .clk_div_i(cdiv),
`ifdef SPI_XFER_LSB_FIRST_EN
        .lsb_first_i(lsb),
`endif
        .busy_o(busy), .done_o(done_o), .err_o(err), .rx_data_o(rx), .cs_n_o(cs_n),
        .mosi_o(mosi), .miso_i(miso), .gen_clock_en_o(gen_en), .gen_clk_div_o(gen_div),
        .gen_clk_div_vld_o(gen_vld), .gen_rise_edge_i(g_rise), .gen_fall_edge_i(g_fall)
    );

    always #5 clk = ~clk;

    // baud generator: SCLK toggles every div/2 cycles, strobe in the cycle before the toggle
    assign g_rise = gen_en && gcnt == int'(gen_div) / 2 - 1 && !sclk;
    assign g_fall = gen_en && gcnt == int'(gen_div) / 2 - 1 && sclk;
    always @(posedge clk) begin
        if (rst || !gen_en) begin gcnt <= 0; sclk <= 0; end
        else if (g_rise || g_fall) begin gcnt <= 0; sclk <= !sclk; end
        else gcnt <= gcnt + 1;
    end

    // slave: samples MOSI at each rise and presents its own word MSB-first (or loops MOSI back)
    always_comb begin
        idx  = rise_tot - rise_base;
        miso = loop ? mosi : (idx >= 0 && idx < W) ? slave[W-1-idx] : 1'b0;
    end
    always @(posedge clk) begin
        if (g_rise) begin rise_tot <= rise_tot + 1; mosi_sh <= {mosi_sh[30:0], mosi}; end
        if (g_fall) fall_tot <= fall_tot + 1;
        if (!cs_n) cs_tot <= cs_tot + 1;
        if (done_o) done_tot <= done_tot + 1;
        if (err) err_tot <= err_tot + 1;
    end

    // act: 0 plain, 1 re-pulse start with 0xFF after 4 rises, 2 assert rst after 4 rises
    task automatic run(input logic [W-1:0] t, input logic [7:0] cd, input int act,
                       output int cyc, output logic [7:0] dseen);
        bit fired = 0;
        @(negedge clk); tx = t; cdiv = cd; start = 1; rise_base = rise_tot;
        @(negedge clk); start = 0; cyc = 1; dseen = gen_div;
        while (!done_o && cyc < 4000) begin
            if (act != 0 && !fired && rise_tot - rise_base == 4) begin
                fired = 1;
                if (act == 1) begin tx = '1; start = 1; end else rst = 1;
            end else begin
                start = 0;
                if (act == 2 && fired) break;
            end
            @(negedge clk); cyc++;
        end
        start = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total_n++; if ({busy, done_o, err, cs_n, mosi, gen_en, gen_vld} !== 7'b0001000)
            $display("FAIL reset_ctl got %b want 0001000", {busy, done_o, err, cs_n, mosi, gen_en, gen_vld}); else pass_n++;
        total_n++; if (rx !== '0) $display("FAIL reset_rx got %h want 00", rx); else pass_n++;
        total_n++; if (gen_div !== 8'd0) $display("FAIL reset_div got %0d want 0", gen_div); else pass_n++;
        rst = 0;
    endtask

    task automatic xfer_check(input string nm, input logic [W-1:0] t, input logic [7:0] cd, input logic [W-1:0] exp_rx);
        int cyc, r0, f0, c0, d0, d, e, got;
        logic [7:0] ds;
        r0 = rise_tot; f0 = fall_tot; c0 = cs_tot; d0 = done_tot;
        run(t, cd, 0, cyc, ds);
        d = int'(cd) & ~1; e = 1 + d / 2 + W * d + d / 2 + 2; got = cyc + 1;
        total_n++; if (done_o !== 1'b1 || rx !== exp_rx) $display("FAIL %s_rx got done=%b rx=%h want done=1 rx=%h", nm, done_o, rx, exp_rx); else pass_n++;
        total_n++; if (mosi_sh[W-1:0] !== t) $display("FAIL %s_mosi got %h want %h", nm, mosi_sh[W-1:0], t); else pass_n++;
        total_n++; if (ds !== 8'(d)) $display("FAIL %s_div got %0d want %0d", nm, ds, d); else pass_n++;
        total_n++; if (rise_tot - r0 != W || fall_tot - f0 != W) $display("FAIL %s_edges got %0d/%0d want %0d/%0d", nm, rise_tot - r0, fall_tot - f0, W, W); else pass_n++;
        total_n++; if (got < e - 2 || got > e + 2) $display("FAIL %s_len got %0d want %0d+-2", nm, got, e); else pass_n++;
        total_n++; if (cs_tot - c0 < d + W * d - 2 || cs_tot - c0 > d + W * d + 2) $display("FAIL %s_cs got %0d want %0d+-2", nm, cs_tot - c0, d + W * d); else pass_n++;
        @(negedge clk);
        total_n++; if (done_o !== 1'b0 || busy !== 1'b0 || cs_n !== 1'b1 || done_tot - d0 != 1)
            $display("FAIL %s_pulse got done=%b busy=%b cs_n=%b n=%0d want 0 0 1 1", nm, done_o, busy, cs_n, done_tot - d0); else pass_n++;
    endtask

    task automatic test_loopback();
        loop = 1;
        xfer_check("loop", 8'hA5, 8'd4, 8'hA5);
    endtask

    task automatic test_err();
        for (int i = 0; i < 2; i++) begin
            int e0 = err_tot;
            @(negedge clk); cdiv = 8'(i); start = 1;
            @(negedge clk); start = 0;
            total_n++; if (err !== 1'b1 || busy !== 1'b0 || cs_n !== 1'b1)
                $display("FAIL err%0d got err=%b busy=%b cs_n=%b want 1 0 1", i, err, busy, cs_n); else pass_n++;
            @(negedge clk);
            total_n++; if (err !== 1'b0 || busy !== 1'b0 || err_tot - e0 != 1)
                $display("FAIL err%0d_pulse got err=%b busy=%b n=%0d want 0 0 1", i, err, busy, err_tot - e0); else pass_n++;
        end
    endtask

    task automatic test_odd_div();
        loop = 1;
        xfer_check("odd", 8'h3C, 8'd7, 8'h3C);
    endtask

    task automatic test_ignore_start();
        int cyc, d0, e0;
        logic [7:0] ds;
        loop = 1; d0 = done_tot; e0 = err_tot;
        run(8'h69, 8'd4, 1, cyc, ds);
        total_n++; if (done_o !== 1'b1 || rx !== 8'h69 || mosi_sh[W-1:0] !== 8'h69)
            $display("FAIL ignore got done=%b rx=%h mosi=%h want 1 69 69", done_o, rx, mosi_sh[W-1:0]); else pass_n++;
        @(negedge clk);
        total_n++; if (done_tot - d0 != 1 || err_tot != e0 || busy !== 1'b0)
            $display("FAIL ignore_once got done_n=%0d err_n=%0d busy=%b want 1 0 0", done_tot - d0, err_tot - e0, busy); else pass_n++;
    endtask

    task automatic test_reset_mid();
        int cyc, d0;
        logic [7:0] ds;
        loop = 1; d0 = done_tot;
        run(8'hC3, 8'd4, 2, cyc, ds);
        total_n++; if ({cs_n, gen_en, busy, done_o} !== 4'b1000 || rx !== '0)
            $display("FAIL rst_mid got cs_n/en/busy/done=%b rx=%h want 1000 00", {cs_n, gen_en, busy, done_o}, rx); else pass_n++;
        rst = 0;
        @(negedge clk);
        total_n++; if (done_tot != d0) $display("FAIL rst_mid_done got %0d want 0", done_tot - d0); else pass_n++;
        xfer_check("after_rst", 8'h5A, 8'd4, 8'h5A);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] t = 8'($urandom);
            logic [7:0] cd = 8'($urandom_range(2, 12));
            loop = 0; slave = 8'($urandom);
            xfer_check($sformatf("rnd%0d", i), t, cd, slave);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        loop = 0; slave = 8'($urandom);
        @(negedge clk); tx = 8'h96; cdiv = 8'd2; start = 1; rise_base = rise_tot;
        while (!done_o && n < 2000) begin @(negedge clk); n++; end
        total_n++; if (done_o !== 1'b1 || busy !== 1'b1 || rx !== slave)
            $display("FAIL b2b_done got done=%b busy=%b rx=%h want 1 1 %h", done_o, busy, rx, slave); else pass_n++;
        @(negedge clk); rise_base = rise_tot;
        total_n++; if (busy !== 1'b0 || err !== 1'b0) $display("FAIL b2b_idle got busy=%b err=%b want 0 0", busy, err); else pass_n++;
        @(negedge clk); start = 0;
        total_n++; if (busy !== 1'b1) $display("FAIL b2b_accept got busy=%b want 1", busy); else pass_n++;
        n = 0;
        while (!done_o && n < 2000) begin @(negedge clk); n++; end
        total_n++; if (done_o !== 1'b1 || rx !== slave || mosi_sh[W-1:0] !== 8'h96)
            $display("FAIL b2b_second got done=%b rx=%h mosi=%h want 1 %h 96", done_o, rx, mosi_sh[W-1:0], slave); else pass_n++;
        @(negedge clk);
    endtask

`ifdef SPI_XFER_LSB_FIRST_EN
    task automatic test_lsb();
        int cyc;
        logic [7:0] ds;
        loop = 1; lsb = 1;
        run(8'h01, 8'd4, 0, cyc, ds);
        total_n++; if (mosi_sh[W-1] !== 1'b1 || rx !== 8'h01)
            $display("FAIL lsb got first=%b rx=%h want 1 01", mosi_sh[W-1], rx); else pass_n++;
        lsb = 0;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_loopback();
        test_err();
        test_odd_div();
        test_ignore_start();
        test_reset_mid();
        test_random();
        test_back_to_back();
`ifdef SPI_XFER_LSB_FIRST_EN
        test_lsb();
`endif
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
